ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, RAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 4096, number of RAM words swept by a clear.
REQ-004 The block SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have clr_start, input, 1, one-cycle pulse requesting a zero-fill of the whole RAM.
REQ-007 The block SHALL have clr_busy, output, 1, high while the zero-fill sweep runs.
REQ-008 For each requester i in {0,1}, the block SHALL have mi_req (in, 1, access request), mi_we (in, 1, 1=write 0=read), mi_addr (in, ADDRESS_WIDTH), mi_wdata (in, DATA_WIDTH).
REQ-009 For each requester i, the block SHALL have mi_gnt (out, 1, access accepted this cycle), mi_rvalid (out, 1, read data valid), mi_rdata (out, DATA_WIDTH, read data).
REQ-010 The block SHALL have ram_wEn (out, 1), ram_addr (out, ADDRESS_WIDTH), ram_dataIn (out, DATA_WIDTH) and ram_dataOut (in, DATA_WIDTH), connecting to one single-port synchronous RAM with a registered read of latency 1 that does not update dataOut on write cycles.

Function
REQ-011 The block SHALL have two states: IDLE (serve requesters) and CLEAR (zero-fill sweep).
REQ-012 In IDLE, at most one requester SHALL be granted per cycle; mi_gnt is combinational from the mi_req inputs and the priority register.
REQ-013 Single request: the requesting port SHALL be granted the same cycle.
REQ-014 Both requesting: the port not granted most recently SHALL be granted (round robin); the priority register updates only on a grant.
REQ-015 On a grant, ram_wEn/ram_addr/ram_dataIn SHALL carry the granted mi_we/mi_addr/mi_wdata that same cycle.
REQ-016 With no grant (or in CLEAR outside the sweep write), ram_wEn SHALL be 0, ram_addr 0 and ram_dataIn 0.
REQ-017 A requester SHALL hold mi_req and its fields stable until mi_gnt; a denied request is not latched by the block.
REQ-018 A granted read SHALL raise mi_rvalid for exactly one cycle, the cycle after the grant, with mi_rdata = ram_dataOut; granted writes produce no rvalid.
REQ-019 mi_rdata SHALL be 0 whenever mi_rvalid is 0.
REQ-020 Back-to-back grants SHALL be sustained at one access per cycle with no bubble.
REQ-021 clr_start in IDLE SHALL move to CLEAR on the next edge; requests presented in the same cycle as clr_start are still served.
REQ-022 In CLEAR, no mi_gnt SHALL assert; each cycle the block writes 0 to address cnt, cnt incrementing from 0.
REQ-023 The write to address DEPTH-1 SHALL be the last CLEAR cycle; the next state is IDLE with cnt returned to 0.
REQ-024 clr_start while in CLEAR SHALL be ignored.
REQ-025 clr_busy SHALL equal (state == CLEAR), registered.
REQ-026 A read granted in the final IDLE cycle before CLEAR SHALL still return its mi_rvalid in the first CLEAR cycle.

Reset
REQ-027 Asserting reset_n low SHALL asynchronously force state IDLE, cnt 0, m0_rvalid/m1_rvalid 0, clr_busy 0, and priority so that m0 wins the first contention.
REQ-028 Reset during CLEAR SHALL abandon the sweep; it is not resumed after reset.

Structure
REQ-029 The state enumeration and the IDLE/CLEAR encodings SHALL be placed in a shared package ram_arb_pkg.
REQ-030 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], output gnt[1:0], internal priority flop).

Verification
REQ-031 After reset, m0 read of 0x010 and m1 read of 0x020 raised together: cycle0 m0_gnt; cycle1 m1_gnt and m0_rvalid; cycle2 m1_rvalid.
REQ-032 m0 writes 0xDEADBEEF to 0x005 granted, next cycle m1 reads 0x005: the cycle after that, m1_rvalid=1 and m1_rdata=0xDEADBEEF.
REQ-033 Both ports requesting continuously for 6 cycles: grants alternate m0,m1,m0,m1,m0,m1 with no idle cycle.
REQ-034 Preload 0x123 = 0x55; pulse clr_start: clr_busy high for exactly 4096 cycles, mi_gnt never asserts, then a read of 0x123 returns 0.
REQ-035 Drop reset_n at sweep address 100: clr_busy falls immediately, state IDLE, address 200 keeps its preloaded value, and the next request is granted at once.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: the top-level operating state.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the requesters and the RAM.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     m0_req;
  logic                     m0_we;
  logic [ADDRESS_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0]    m0_wdata;
  logic                     m0_gnt;
  logic                     m0_rvalid;
  logic [DATA_WIDTH-1:0]    m0_rdata;

  logic                     m1_req;
  logic                     m1_we;
  logic [ADDRESS_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0]    m1_wdata;
  logic                     m1_gnt;
  logic                     m1_rvalid;
  logic [DATA_WIDTH-1:0]    m1_rdata;

  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut
  );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins at once, a contention goes
// to the port that was not granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (gnt[0]) last_d = 1'b0;
    if (gnt[1]) last_d = 1'b1;
  end

  // Reset as "m1 last" so m0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port synchronous RAM and can
// zero-fill the whole RAM in a sweep that blocks both requesters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_start,
  output logic            clr_busy,
  ram_arbiter_if.slave    bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]               rvalid_q, rvalid_d;
  logic [1:0]               req, gnt;
  logic                     ram_wen;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_din;

  // Requests are masked during the sweep so the arbiter's priority stays frozen.
  assign req = {bus.m1_req, bus.m0_req} & {2{state_q == IDLE}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = {gnt[1] & ~bus.m1_we, gnt[0] & ~bus.m0_we};
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          ram_wen  = bus.m0_we;
          ram_addr = bus.m0_addr;
          ram_din  = bus.m0_wdata;
        end else if (gnt[1]) begin
          ram_wen  = bus.m1_we;
          ram_addr = bus.m1_addr;
          ram_din  = bus.m1_wdata;
        end
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        ram_wen  = 1'b1;
        ram_addr = cnt_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDRESS_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign clr_busy       = (state_q == CLEAR);
  assign bus.m0_gnt     = gnt[0];
  assign bus.m1_gnt     = gnt[1];
  assign bus.m0_rvalid  = rvalid_q[0];
  assign bus.m1_rvalid  = rvalid_q[1];
  // RAM output is only meaningful the cycle after a read grant; mask it otherwise.
  assign bus.m0_rdata   = rvalid_q[0] ? bus.ram_dataOut : '0;
  assign bus.m1_rdata   = rvalid_q[1] ? bus.ram_dataOut : '0;
  assign bus.ram_wEn    = ram_wen;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_dataIn = ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM plus a reference model of expected
// memory contents, grant order and read returns.
module tb_ram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr_start = 1'b0;
  logic clr_busy;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .bus       (bus)
  );

  // Single-port RAM, registered read, dataOut held on write cycles.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] seed [DEPTH];
  logic          preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed[i];
    end else if (bus.ram_wEn) begin
      mem[bus.ram_addr] <= bus.ram_dataIn;
    end else begin
      bus.ram_dataOut <= mem[bus.ram_addr];
    end
  end

  // Reference model
  logic [DW-1:0] mem_m [DEPTH];
  int            last_m;
  bit            pend_v [2];
  logic [DW-1:0] pend_d [2];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic req_of(int p);
    return (p == 1) ? bus.m1_req : bus.m0_req;
  endfunction
  function automatic logic we_of(int p);
    return (p == 1) ? bus.m1_we : bus.m0_we;
  endfunction
  function automatic logic [AW-1:0] addr_of(int p);
    return (p == 1) ? bus.m1_addr : bus.m0_addr;
  endfunction
  function automatic logic [DW-1:0] wdata_of(int p);
    return (p == 1) ? bus.m1_wdata : bus.m0_wdata;
  endfunction

  // Who should win this cycle: lone requester, else whoever did not win last.
  function automatic int exp_grant(logic r0, logic r1);
    if (r0 && r1) return (last_m == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_step(input int gp);
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    if (gp >= 0) begin
      last_m = gp;
      if (we_of(gp)) mem_m[addr_of(gp)] = wdata_of(gp);
      else begin
        pend_v[gp] = 1'b1;
        pend_d[gp] = mem_m[addr_of(gp)];
      end
    end
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    #1;
    n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
    n_cmp++; if (bus.m0_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_m0_rvalid: got %b want 0", bus.m0_rvalid); end
    n_cmp++; if (bus.m1_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_m1_rvalid: got %b want 0", bus.m1_rvalid); end
    n_cmp++; if (bus.m0_rdata !== '0) begin n_err++; $display("FAIL reset_m0_rdata: got %h want 0", bus.m0_rdata); end
    reset_n = 1'b1;
    last_m = 1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin n_err++; $display("FAIL idle_gnt: got %b want 00", {bus.m1_gnt, bus.m0_gnt}); end
    n_cmp++; if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== '0) begin n_err++; $display("FAIL idle_ram_bus: got %b/%h/%h want 0/0/0", bus.ram_wEn, bus.ram_addr, bus.ram_dataIn); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 12'h010;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h020;
    #1;
    n_cmp++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin n_err++; $display("FAIL cont_c0_gnt: got %b want 01", {bus.m1_gnt, bus.m0_gnt}); end
    n_cmp++; if (bus.ram_addr !== 12'h010 || bus.ram_wEn !== 1'b0) begin n_err++; $display("FAIL cont_c0_ram: got %b/%h want 0/010", bus.ram_wEn, bus.ram_addr); end
    model_step(0);
    @(negedge clk); bus.m0_req = 1'b0; #1;
    n_cmp++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin n_err++; $display("FAIL cont_c1_gnt: got %b want 10", {bus.m1_gnt, bus.m0_gnt}); end
    n_cmp++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== pend_d[0]) begin n_err++; $display("FAIL cont_c1_m0_read: got %b/%h want 1/%h", bus.m0_rvalid, bus.m0_rdata, pend_d[0]); end
    model_step(1);
    @(negedge clk); bus.m1_req = 1'b0; #1;
    n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== pend_d[1]) begin n_err++; $display("FAIL cont_c2_m1_read: got %b/%h want 1/%h", bus.m1_rvalid, bus.m1_rdata, pend_d[1]); end
    n_cmp++; if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== '0) begin n_err++; $display("FAIL cont_c2_m0_quiet: got %b/%h want 0/0", bus.m0_rvalid, bus.m0_rdata); end
    model_step(-1);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h005; bus.m0_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.m0_gnt !== 1'b1 || bus.ram_wEn !== 1'b1 || bus.ram_addr !== 12'h005 || bus.ram_dataIn !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_grant: got gnt=%b we=%b a=%h d=%h want 1/1/005/deadbeef", bus.m0_gnt, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn); end
    model_step(0);
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h005;
    #1;
    n_cmp++; if (bus.m1_gnt !== 1'b1 || bus.ram_wEn !== 1'b0 || bus.m0_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rd_grant: got gnt=%b we=%b m0_rvalid=%b want 1/0/0", bus.m1_gnt, bus.ram_wEn, bus.m0_rvalid); end
    model_step(1);
    @(negedge clk); bus.m1_req = 1'b0; #1;
    n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL raw_rdata: got %b/%h want 1/deadbeef", bus.m1_rvalid, bus.m1_rdata); end
    model_step(-1);
  endtask

  task automatic test_back_to_back();
    int exp;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = AW'($urandom);
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = AW'($urandom);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if ((k - 1) % 2 == 0) bus.m0_addr = AW'($urandom);
        else                  bus.m1_addr = AW'($urandom);
      end
      #1;
      exp = k % 2;
      n_cmp++; if (bus.m0_gnt !== (exp == 0) || bus.m1_gnt !== (exp == 1)) begin
        n_err++; $display("FAIL b2b_gnt_%0d: got %b want m%0d", k, {bus.m1_gnt, bus.m0_gnt}, exp); end
      if (k > 0) begin
        if (exp == 1) begin
          n_cmp++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== pend_d[0]) begin
            n_err++; $display("FAIL b2b_rd_%0d: got %b/%h want 1/%h", k, bus.m0_rvalid, bus.m0_rdata, pend_d[0]); end
        end else begin
          n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== pend_d[1]) begin
            n_err++; $display("FAIL b2b_rd_%0d: got %b/%h want 1/%h", k, bus.m1_rvalid, bus.m1_rdata, pend_d[1]); end
        end
      end
      model_step(exp);
    end
    @(negedge clk); bus.m0_req = 1'b0; bus.m1_req = 1'b0; #1;
    n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== pend_d[1]) begin
      n_err++; $display("FAIL b2b_rd_last: got %b/%h want 1/%h", bus.m1_rvalid, bus.m1_rdata, pend_d[1]); end
    model_step(-1);
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int gnt_seen = 0;
    int sweep_bad = 0;
    bit first = 1'b1;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h123; bus.m0_wdata = 32'h55;
    #1;
    n_cmp++; if (bus.m0_gnt !== 1'b1) begin n_err++; $display("FAIL clr_preload_gnt: got %b want 1", bus.m0_gnt); end
    model_step(0);
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    clr_start = 1'b1;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h124;
    #1;
    n_cmp++; if (bus.m1_gnt !== 1'b1) begin n_err++; $display("FAIL clr_same_cycle_gnt: got %b want 1", bus.m1_gnt); end
    model_step(1);
    @(negedge clk);
    clr_start = 1'b0;
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 12'h123;
    for (int guard = 0; guard < 5000; guard++) begin
      #1;
      if (!clr_busy) break;
      if (first) begin
        n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== pend_d[1]) begin
          n_err++; $display("FAIL clr_first_rvalid: got %b/%h want 1/%h", bus.m1_rvalid, bus.m1_rdata, pend_d[1]); end
        first = 1'b0;
      end
      if (bus.m0_gnt || bus.m1_gnt) gnt_seen++;
      if (bus.ram_wEn !== 1'b1 || bus.ram_addr !== AW'(busy_cnt) || bus.ram_dataIn !== '0) sweep_bad++;
      busy_cnt++;
      clr_start = (busy_cnt == 2000);
      @(negedge clk);
      clr_start = 1'b0;
    end
    n_cmp++; if (busy_cnt !== DEPTH) begin n_err++; $display("FAIL clr_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_cmp++; if (gnt_seen !== 0) begin n_err++; $display("FAIL clr_gnt_during_sweep: got %0d want 0", gnt_seen); end
    n_cmp++; if (sweep_bad !== 0) begin n_err++; $display("FAIL clr_sweep_writes: got %0d bad want 0", sweep_bad); end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    n_cmp++; if (bus.m0_gnt !== 1'b1 || bus.ram_addr !== 12'h123) begin
      n_err++; $display("FAIL clr_after_gnt: got %b/%h want 1/123", bus.m0_gnt, bus.ram_addr); end
    model_step(0);
    @(negedge clk); bus.m0_req = 1'b0; #1;
    n_cmp++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0) begin
      n_err++; $display("FAIL clr_readback: got %b/%h want 1/0", bus.m0_rvalid, bus.m0_rdata); end
    model_step(-1);
  endtask

  task automatic test_reset_clear();
    bit found = 1'b0;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'd200; bus.m0_wdata = 32'hA5A50200;
    #1;
    n_cmp++; if (bus.m0_gnt !== 1'b1) begin n_err++; $display("FAIL rstclr_preload_gnt: got %b want 1", bus.m0_gnt); end
    model_step(0);
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    clr_start = 1'b1;
    #1;
    model_step(-1);
    @(negedge clk);
    clr_start = 1'b0;
    for (int guard = 0; guard < 300; guard++) begin
      #1;
      if (clr_busy && bus.ram_addr == 12'd100) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rstclr_reach_100: got %b want 1", found); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (clr_busy !== 1'b0 || bus.ram_wEn !== 1'b0) begin
      n_err++; $display("FAIL rstclr_async: got busy=%b wEn=%b want 0/0", clr_busy, bus.ram_wEn); end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) mem_m[i] = '0;
    last_m = 1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'd200;
    #1;
    n_cmp++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin n_err++; $display("FAIL rstclr_gnt: got %b want 10", {bus.m1_gnt, bus.m0_gnt}); end
    model_step(1);
    @(negedge clk); bus.m1_req = 1'b0; #1;
    n_cmp++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hA5A50200) begin
      n_err++; $display("FAIL rstclr_keep_200: got %b/%h want 1/a5a50200", bus.m1_rvalid, bus.m1_rdata); end
    model_step(-1);
  endtask

  task automatic test_random();
    int exp;
    int prev_g = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (prev_g == 0) bus.m0_req = 1'b0;
      if (prev_g == 1) bus.m1_req = 1'b0;
      if (!bus.m0_req && $urandom_range(0, 1) == 1) begin
        bus.m0_req = 1'b1; bus.m0_we = 1'($urandom_range(0, 1));
        bus.m0_addr = AW'($urandom_range(0, 31)); bus.m0_wdata = $urandom;
      end
      if (!bus.m1_req && $urandom_range(0, 1) == 1) begin
        bus.m1_req = 1'b1; bus.m1_we = 1'($urandom_range(0, 1));
        bus.m1_addr = AW'($urandom_range(0, 31)); bus.m1_wdata = $urandom;
      end
      #1;
      exp = exp_grant(bus.m0_req, bus.m1_req);
      n_cmp++; if (bus.m0_gnt !== (exp == 0) || bus.m1_gnt !== (exp == 1)) begin
        n_err++; $display("FAIL rnd_gnt_%0d: got %b want port %0d", k, {bus.m1_gnt, bus.m0_gnt}, exp); end
      if (exp >= 0) begin
        n_cmp++; if (bus.ram_wEn !== we_of(exp) || bus.ram_addr !== addr_of(exp) || bus.ram_dataIn !== wdata_of(exp)) begin
          n_err++; $display("FAIL rnd_ram_%0d: got %b/%h/%h want %b/%h/%h", k, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn, we_of(exp), addr_of(exp), wdata_of(exp)); end
      end else begin
        n_cmp++; if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== '0) begin
          n_err++; $display("FAIL rnd_ram_idle_%0d: got %b/%h/%h want 0/0/0", k, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn); end
      end
      n_cmp++; if (bus.m0_rvalid !== pend_v[0] || bus.m0_rdata !== (pend_v[0] ? pend_d[0] : '0)) begin
        n_err++; $display("FAIL rnd_m0_rd_%0d: got %b/%h want %b/%h", k, bus.m0_rvalid, bus.m0_rdata, pend_v[0], pend_v[0] ? pend_d[0] : '0); end
      n_cmp++; if (bus.m1_rvalid !== pend_v[1] || bus.m1_rdata !== (pend_v[1] ? pend_d[1] : '0)) begin
        n_err++; $display("FAIL rnd_m1_rd_%0d: got %b/%h want %b/%h", k, bus.m1_rvalid, bus.m1_rdata, pend_v[1], pend_v[1] ? pend_d[1] : '0); end
      model_step(exp);
      prev_g = exp;
    end
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      seed[i]  = $urandom;
      mem_m[i] = seed[i];
    end
    last_m = 1;
    test_reset();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_reset_clear();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
